// File: rtl/mem_bus_responder.sv
// Word-addressed memory slave on a shared tristate data bus, with a one-cycle rdy/err response.
// Define MEM_BUS_RESPONDER_WAIT_EN to insert WAIT_CYCLES wait states per access (default: none).
module mem_bus_responder #(
  parameter int unsigned ADDR_WIDTH  = 28,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] addr,
  inout  wire  [DATA_WIDTH-1:0] data,
  input  logic                  cs,
  input  logic                  we,
  input  logic                  oe,
  output logic                  rdy,
  output logic                  err
);

  if (WAIT_CYCLES > 15) begin : g_wait_range
    $error("WAIT_CYCLES must be within 0..15");
  end

`ifdef MEM_BUS_RESPONDER_WAIT_EN
  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;
  localparam logic [3:0] WaitLoad = 4'(WAIT_CYCLES - 1);
  logic [3:0] cnt_q, cnt_d;
`else
  typedef enum logic [1:0] {StIdle, StResp} state_e;
`endif

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    we_q, we_d;
  logic                    oe_q, oe_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;

  logic [DATA_WIDTH-1:0]   mem [2**DEPTH_LOG2];

  logic                    qualified, accept, enter_resp;
  logic [ADDR_WIDTH-1:0]   acc_addr;
  logic                    acc_we, acc_oe, acc_ok;
  logic [DATA_WIDTH-1:0]   acc_data;
  logic [DEPTH_LOG2-1:0]   acc_idx;
  logic                    mem_we;

  assign qualified = cs & (we | oe);
  assign accept    = qualified & ((state_q == StIdle) | (state_q == StResp));

  // The access entering RESP is the incoming one on a zero-wait accept, else the latched one.
  assign acc_addr = accept ? addr : addr_q;
  assign acc_we   = accept ? we   : we_q;
  assign acc_oe   = accept ? oe   : oe_q;
  assign acc_data = accept ? data : wdata_q;
  assign acc_idx  = acc_addr[DEPTH_LOG2-1:0];
  assign acc_ok   = ~(acc_we & acc_oe) & (acc_addr[ADDR_WIDTH-1:DEPTH_LOG2] == '0);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    we_d       = we_q;
    oe_d       = oe_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = 1'b0;
    enter_resp = 1'b0;
`ifdef MEM_BUS_RESPONDER_WAIT_EN
    cnt_d      = cnt_q;
`endif
    unique case (state_q)
`ifdef MEM_BUS_RESPONDER_WAIT_EN
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d    = StResp;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
`endif
      default: begin
        if (accept) begin
          addr_d  = addr;
          we_d    = we;
          oe_d    = oe;
          wdata_d = data;
`ifdef MEM_BUS_RESPONDER_WAIT_EN
          if (WAIT_CYCLES > 0) begin
            state_d = StWait;
            cnt_d   = WaitLoad;
          end else begin
            state_d    = StResp;
            enter_resp = 1'b1;
          end
`else
          state_d    = StResp;
          enter_resp = 1'b1;
`endif
        end else begin
          state_d = StIdle;
        end
      end
    endcase
    if (enter_resp) begin
      err_d   = ~acc_ok;
      rdata_d = (acc_ok & acc_oe & ~acc_we) ? mem[acc_idx] : '0;
    end
  end

  // Gated by rst_n so an access presented while in reset can never commit.
  assign mem_we = enter_resp & acc_ok & acc_we & rst_n;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[acc_idx] <= acc_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      we_q    <= 1'b0;
      oe_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
`ifdef MEM_BUS_RESPONDER_WAIT_EN
      cnt_q   <= 4'd0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      oe_q    <= oe_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
`ifdef MEM_BUS_RESPONDER_WAIT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign rdy  = (state_q == StResp);
  assign err  = err_q;
  assign data = ((state_q == StResp) & oe_q & ~we_q & oe & cs) ? rdata_q : 'z;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Randomized bench for mem_bus_responder against a transaction-level memory/latency model.
module tb_mem_bus_responder;

`ifdef MEM_BUS_RESPONDER_WAIT_EN
  localparam int unsigned TbWait = 2;
  localparam int unsigned EffW   = 2;
`else
  localparam int unsigned TbWait = 5;
  localparam int unsigned EffW   = 0;
`endif
  localparam int Lat = int'(EffW) + 1;

  logic        clk;
  logic        rst_n;
  logic [27:0] addr;
  logic        cs, we, oe;
  logic        rdy, err;
  logic        tb_drv;
  logic [31:0] tb_val;
  tri1  [31:0] data;

  assign data = tb_drv ? tb_val : 'z;

  mem_bus_responder #(
    .ADDR_WIDTH (28),
    .DATA_WIDTH (32),
    .DEPTH_LOG2 (10),
    .WAIT_CYCLES(TbWait)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .addr (addr),
    .data (data),
    .cs   (cs),
    .we   (we),
    .oe   (oe),
    .rdy  (rdy),
    .err  (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: memory image plus the single outstanding access and its response cycle.
  logic [31:0] mem_m [1024];
  bit          known [1024];
  bit          pend;
  int          p_resp;
  logic [27:0] p_addr;
  bit          p_we, p_oe;
  logic [31:0] p_wdata;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic cycle(input bit r, input bit c, input bit w, input bit o,
                       input logic [27:0] a, input logic [31:0] d);
    bit          resp_now, r_err, r_rd, r_known;
    logic [31:0] r_data;
    int          idx;
    @(negedge clk);
    rst_n  = r;
    cs     = c;
    we     = w;
    oe     = o;
    addr   = a;
    tb_drv = w & ~o;
    tb_val = d;
    #1;
    cyc++;
    resp_now = pend && (p_resp == cyc);
    r_err    = 1'b0;
    r_rd     = 1'b0;
    r_known  = 1'b1;
    r_data   = '0;
    if (resp_now) begin
      pend  = 1'b0;
      idx   = int'(p_addr[9:0]);
      r_err = (p_we && p_oe) || (p_addr[27:10] != '0);
      r_rd  = p_oe && !p_we;
      if (!r_err && p_we) begin
        mem_m[idx] = p_wdata;
        known[idx] = 1'b1;
      end
      if (r_rd && !r_err) begin
        r_data  = mem_m[idx];
        r_known = known[idx];
      end
    end
    if (!r) begin
      resp_now = 1'b0;
      pend     = 1'b0;
    end
    check_eq("rdy", {31'b0, rdy}, {31'b0, resp_now});
    check_eq("err", {31'b0, err}, {31'b0, resp_now & r_err});
    if (!tb_drv) begin
      if (resp_now && r_rd && o && c) begin
        if (r_known) check_eq("rdata", data, r_data);
      end else begin
        check_eq("data_hiz", data, 32'hFFFF_FFFF);
      end
    end
    if (r && c && (w || o) && !pend) begin
      pend    = 1'b1;
      p_resp  = cyc + Lat;
      p_addr  = a;
      p_we    = w;
      p_oe    = o;
      p_wdata = d;
    end
  endtask

  function automatic logic [27:0] pick_addr();
    logic [27:0] v;
    case ($urandom_range(0, 5))
      0:       v = 28'h100 + 28'($urandom_range(0, 32));
      1:       v = 28'($urandom_range(0, 7));
      2:       v = 28'h3FF;
      3:       v = 28'h400;
      4:       v = 28'hFFF_FFFF;
      default: v = 28'h10D;
    endcase
    return v;
  endfunction

  // One access, then read attempts during its wait states that must be ignored.
  task automatic acc(input bit w, input bit o, input logic [27:0] a, input logic [31:0] d);
    cycle(1'b1, 1'b1, w, o, a, d);
    for (int k = 1; k < Lat; k++) cycle(1'b1, 1'b1, 1'b0, 1'b1, pick_addr(), 32'h0);
  endtask

  task automatic idle();
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 28'h0, 32'h0);
  endtask

  initial begin
    logic [31:0] vals [17];
    pend   = 1'b0;
    rst_n  = 1'b0;
    cs     = 1'b0;
    we     = 1'b0;
    oe     = 1'b0;
    addr   = '0;
    tb_drv = 1'b0;
    tb_val = '0;
    for (int i = 0; i < 1024; i++) known[i] = 1'b0;

    repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b0, 28'h0, 32'h0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 28'h100, 32'h1234_5678);

    acc(1'b1, 1'b0, 28'h000, 32'hA5A5_0000);
    acc(1'b1, 1'b0, 28'h100, 32'h1000_011E);
    acc(1'b0, 1'b1, 28'h100, 32'h0);
    acc(1'b0, 1'b1, 28'h100, 32'h0);

    for (int i = 0; i < 17; i++) begin
      vals[i] = $urandom;
      acc(1'b1, 1'b0, 28'h100 + 28'(2 * i), vals[i]);
    end
    for (int i = 0; i < 17; i++) acc(1'b0, 1'b1, 28'h100 + 28'(2 * i), 32'h0);
    acc(1'b0, 1'b1, 28'h104, 32'h0);
    acc(1'b0, 1'b1, 28'h104, 32'h0);
    idle();

    acc(1'b1, 1'b0, 28'h400, 32'h0000_0005);
    acc(1'b0, 1'b1, 28'h400, 32'h0);
    acc(1'b0, 1'b1, 28'h000, 32'h0);
    acc(1'b0, 1'b1, 28'h000, 32'h0);
    idle();

    acc(1'b1, 1'b0, 28'h10D, 32'h0000_ABCD);
    acc(1'b0, 1'b1, 28'h10D, 32'h0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 28'h10D, 32'h0000_FFFF);
    repeat (2) cycle(1'b0, 1'b1, 1'b0, 1'b1, 28'h10D, 32'h0);
    acc(1'b0, 1'b1, 28'h10D, 32'h0);
    acc(1'b0, 1'b1, 28'h10D, 32'h0);
    idle();

    acc(1'b1, 1'b1, 28'h102, 32'h0);
    acc(1'b0, 1'b1, 28'h102, 32'h0);
    acc(1'b0, 1'b1, 28'h102, 32'h0);
    idle();

    repeat (800) begin
      cycle(($urandom_range(0, 40) != 0), ($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pick_addr(), $urandom);
    end
    repeat (8) idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
